// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and widths for the memory port arbiter
package mem_arb_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE,
        BUSY_I,
        BUSY_D,
        DONE
    } arb_state_t;

    typedef enum logic {
        SRC_IF,
        SRC_D
    } grant_src_t;

    // Smallest counter width able to hold max_val (at least one bit).
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requester, memory and pipeline signals of the arbiter
interface mem_port_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) ();

    logic              if_req;
    logic [ADDR_W-1:0] if_adr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_done;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_adr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_done;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_adr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    logic              stall;
    logic              err;

    // Arbiter side.
    modport slave (
        input  if_req, if_adr, d_req, d_we, d_adr, d_wdata, mem_ack, mem_rdata,
        output if_rdata, if_done, d_rdata, d_done,
        output mem_req, mem_we, mem_adr, mem_wdata, stall, err
    );

    // Requesters, memory and pipeline side.
    modport master (
        output if_req, if_adr, d_req, d_we, d_adr, d_wdata, mem_ack, mem_rdata,
        input  if_rdata, if_done, d_rdata, d_done,
        input  mem_req, mem_we, mem_adr, mem_wdata, stall, err
    );

endinterface

// File: rtl/mem_arb_prio.sv
// rtl/mem_arb_prio.sv - fetch/data priority select with saturating starvation counter
module mem_arb_prio
    import mem_arb_pkg::*;
#(
    parameter  int STARVE_MAX = 3,
    localparam int CNT_W      = cnt_width(STARVE_MAX)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             if_req,
    input  logic             d_req,
    input  logic             grant,
    output grant_src_t       src,
    output logic [CNT_W-1:0] starve_cnt
);

    logic at_max;

    assign at_max = (starve_cnt == CNT_W'(STARVE_MAX));

    // Data wins contention until fetch has been passed over STARVE_MAX times.
    always_comb begin
        src = SRC_D;
        if (if_req && (!d_req || at_max)) begin
            src = SRC_IF;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (grant) begin
            if (src == SRC_IF) begin
                starve_cnt <= '0;
            end else if (if_req && !at_max) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between fetch and data requesters
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W          = ADDR_W_DEF,
    parameter int DATA_W          = DATA_W_DEF,
    parameter int STARVE_MAX      = 3,
    parameter int TIMEOUT         = 255,
    parameter int DATA_REGION_BIT = 31
) (
    input  logic                clk,
    input  logic                reset,
    mem_port_arbiter_if.slave   bus
);

    localparam int TO_W = cnt_width(TIMEOUT);
    localparam int SC_W = cnt_width(STARVE_MAX);
    localparam logic [ADDR_W-1:0] REGION_MASK =
        (DATA_REGION_BIT < ADDR_W) ? (ADDR_W'(1) << DATA_REGION_BIT) : '0;

    arb_state_t      state;
    grant_src_t      src;
    logic [TO_W-1:0] to_cnt;
    logic [SC_W-1:0] starve_cnt_unused;
    logic            any_req;
    logic            grant;
    logic            timed_out;
    logic            finish;

    assign any_req   = bus.if_req | bus.d_req;
    assign grant     = (state == IDLE) && any_req;
    assign timed_out = (TIMEOUT != 0) && (to_cnt == TO_W'(TIMEOUT - 1));
    assign finish    = bus.mem_ack || timed_out;

    mem_arb_prio #(
        .STARVE_MAX (STARVE_MAX)
    ) u_prio (
        .clk        (clk),
        .reset      (reset),
        .if_req     (bus.if_req),
        .d_req      (bus.d_req),
        .grant      (grant),
        .src        (src),
        .starve_cnt (starve_cnt_unused)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            to_cnt        <= '0;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_adr   <= '0;
            bus.mem_wdata <= '0;
            bus.if_rdata  <= '0;
            bus.d_rdata   <= '0;
            bus.if_done   <= 1'b0;
            bus.d_done    <= 1'b0;
            bus.stall     <= 1'b0;
            bus.err       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bus.if_done <= 1'b0;
                    bus.d_done  <= 1'b0;
                    to_cnt      <= '0;
                    bus.stall   <= any_req;
                    if (any_req) begin
                        bus.mem_req <= 1'b1;
                        if (src == SRC_IF) begin
                            state       <= BUSY_I;
                            bus.mem_adr <= bus.if_adr;
                            bus.mem_we  <= 1'b0;
                        end else begin
                            state         <= BUSY_D;
                            bus.mem_adr   <= bus.d_adr | REGION_MASK;
                            bus.mem_we    <= bus.d_we;
                            bus.mem_wdata <= bus.d_wdata;
                        end
                    end
                end
                BUSY_I, BUSY_D: begin
                    // An ack on the timeout cycle still counts as a normal completion.
                    if (finish) begin
                        state       <= DONE;
                        to_cnt      <= '0;
                        bus.mem_req <= 1'b0;
                        bus.stall   <= 1'b0;
                        if (!bus.mem_ack) begin
                            bus.err <= 1'b1;
                        end
                        if (state == BUSY_I) begin
                            bus.if_done  <= 1'b1;
                            bus.if_rdata <= bus.mem_ack ? bus.mem_rdata : '0;
                        end else begin
                            bus.d_done  <= 1'b1;
                            bus.d_rdata <= bus.mem_ack ? bus.mem_rdata : '0;
                        end
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                DONE: begin
                    bus.if_done <= 1'b0;
                    bus.d_done  <= 1'b0;
                    bus.stall   <= any_req;
                    state       <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed and randomized checks against a transaction-level model
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int STARVE = 3;
    localparam int TO     = 4;

    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   starve  = 0;
    bit   exp_err = 1'b0;
    string order;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_port_arbiter #(
        .ADDR_W          (32),
        .DATA_W          (32),
        .STARVE_MAX      (STARVE),
        .TIMEOUT         (TO),
        .DATA_REGION_BIT (31)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One full transaction starting from IDLE with the current request inputs.
    task automatic txn(input int k, input logic [31:0] rd, input bit to, input bit drop, input bit keep);
        bit          is_d;
        logic [31:0] eadr;
        logic [31:0] erd;
        bit          ewe;
        logic [31:0] ewd;
        is_d = bus.d_req && !(bus.if_req && starve == STARVE);
        eadr = is_d ? (bus.d_adr | 32'h8000_0000) : bus.if_adr;
        ewe  = is_d ? bus.d_we : 1'b0;
        ewd  = bus.d_wdata;
        if (is_d) begin
            if (bus.if_req && starve < STARVE) starve++;
        end else begin
            starve = 0;
        end
        order = {order, is_d ? "D" : "I"};

        tick();
        chk("grant_mem_req", bus.mem_req, 1);
        chk("grant_mem_adr", bus.mem_adr, eadr);
        chk("grant_mem_we", bus.mem_we, ewe);
        if (ewe) chk("grant_mem_wdata", bus.mem_wdata, ewd);
        chk("grant_stall", bus.stall, 1);
        chk("grant_done", {bus.if_done, bus.d_done}, 0);
        if (drop) begin
            if (is_d) bus.d_req = 1'b0;
            else      bus.if_req = 1'b0;
        end

        if (to) begin
            repeat (TO - 1) begin
                tick();
                chk("wait_mem_req", bus.mem_req, 1);
                chk("wait_done", {bus.if_done, bus.d_done}, 0);
            end
            tick();
            exp_err = 1'b1;
            erd     = 32'h0;
        end else begin
            repeat (k) begin
                tick();
                chk("wait_mem_req", bus.mem_req, 1);
                chk("wait_mem_adr", bus.mem_adr, eadr);
                chk("wait_done", {bus.if_done, bus.d_done}, 0);
            end
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = rd;
            tick();
            bus.mem_ack   = 1'b0;
            bus.mem_rdata = $urandom;
            erd = rd;
        end

        chk(is_d ? "d_done" : "if_done", is_d ? bus.d_done : bus.if_done, 1);
        chk(is_d ? "if_done_idle" : "d_done_idle", is_d ? bus.if_done : bus.d_done, 0);
        chk(is_d ? "d_rdata" : "if_rdata", is_d ? bus.d_rdata : bus.if_rdata, erd);
        chk("done_mem_req", bus.mem_req, 0);
        chk("done_stall", bus.stall, 0);
        chk("err", bus.err, exp_err);
        if (!keep && !drop) begin
            if (is_d) bus.d_req = 1'b0;
            else      bus.if_req = 1'b0;
        end

        tick();
        chk("idle_done", {bus.if_done, bus.d_done}, 0);
        chk("idle_mem_req", bus.mem_req, 0);
        chk("idle_stall", bus.stall, bus.if_req | bus.d_req);
    endtask

    initial begin
        reset         = 1'b1;
        bus.if_req    = 1'b0;
        bus.if_adr    = '0;
        bus.d_req     = 1'b0;
        bus.d_we      = 1'b0;
        bus.d_adr     = '0;
        bus.d_wdata   = '0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        #3;
        chk("rst_mem_req", bus.mem_req, 0);
        chk("rst_mem_adr", bus.mem_adr, 0);
        chk("rst_stall", bus.stall, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_done", {bus.if_done, bus.d_done}, 0);
        chk("rst_rdata", bus.if_rdata | bus.d_rdata, 0);
        tick();
        tick();
        reset = 1'b0;
        tick();

        // Lone fetch, two wait cycles.
        bus.if_req = 1'b1;
        bus.if_adr = 32'h10;
        txn(2, 32'h0050_0093, 0, 0, 0);

        // Store, zero wait: region bit forced.
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b1;
        bus.d_adr   = 32'h40;
        bus.d_wdata = 32'hDEAD_BEEF;
        txn(0, 32'h1234_5678, 0, 0, 0);
        bus.d_we = 1'b0;

        // Stray ack while idle.
        bus.mem_ack = 1'b1;
        tick();
        bus.mem_ack = 1'b0;
        chk("stray_ack_mem_req", bus.mem_req, 0);
        chk("stray_ack_done", {bus.if_done, bus.d_done}, 0);

        // Load that never gets an ack, then a good fetch with err still set.
        bus.d_req = 1'b1;
        bus.d_adr = 32'h8000_0100;
        txn(0, 32'h0, 1, 0, 0);
        bus.if_req = 1'b1;
        bus.if_adr = 32'h14;
        txn(1, 32'hCAFE_F00D, 0, 0, 0);

        // Both requesters held high.
        order       = "";
        bus.if_req  = 1'b1;
        bus.if_adr  = 32'h20;
        bus.d_req   = 1'b1;
        bus.d_adr   = 32'h44;
        bus.d_wdata = 32'h0;
        for (int i = 0; i < 8; i++) begin
            txn($urandom_range(0, 2), $urandom, 0, 0, 1);
        end
        n_tests++;
        assert (order == "DDDIDDDI") else begin
            n_fail++;
            $error("FAIL grant_order: observed %s expected DDDIDDDI", order);
        end
        bus.if_req = 1'b0;
        bus.d_req  = 1'b0;
        tick();

        // Asynchronous reset in the middle of a data transaction.
        bus.d_req = 1'b1;
        bus.d_adr = 32'h88;
        tick();
        chk("pre_rst_mem_req", bus.mem_req, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_mem_req", bus.mem_req, 0);
        chk("async_rst_stall", bus.stall, 0);
        chk("async_rst_err", bus.err, 0);
        bus.d_req = 1'b0;
        #2;
        reset   = 1'b0;
        starve  = 0;
        exp_err = 1'b0;
        tick();
        bus.if_req = 1'b1;
        bus.if_adr = $urandom;
        txn(0, $urandom, 0, 0, 0);

        // Fetch withdrawn right after grant.
        bus.if_req = 1'b1;
        bus.if_adr = 32'h30;
        txn(1, 32'h0000_0013, 0, 1, 0);
        repeat (3) begin
            tick();
            chk("withdraw_no_redone", bus.if_done, 0);
            chk("withdraw_no_req", bus.mem_req, 0);
        end

        // Random traffic; pending requests stay held until served.
        for (int n = 0; n < 24; n++) begin
            if (!bus.if_req && $urandom_range(0, 1) == 1) begin
                bus.if_req = 1'b1;
                bus.if_adr = $urandom;
            end
            if (!bus.d_req && $urandom_range(0, 1) == 1) begin
                bus.d_req   = 1'b1;
                bus.d_we    = 1'($urandom_range(0, 1));
                bus.d_adr   = $urandom;
                bus.d_wdata = $urandom;
            end
            if (!bus.if_req && !bus.d_req) begin
                bus.d_req   = 1'b1;
                bus.d_we    = 1'($urandom_range(0, 1));
                bus.d_adr   = $urandom;
                bus.d_wdata = $urandom;
            end
            txn($urandom_range(0, 2), $urandom, 0, 0, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
